v810_intc: RTL and testbench
============================

// Module: v810_intc
// PURPOSE
// Interrupt controller that drives the V810 interrupt inputs (INT, INTVn, NMIn) from external request lines.
// Latches, masks and prioritises up to 16 maskable sources (source i = interrupt level i) and one NMI source.
// Software programs and services it as a 32-bit bus slave on the V810 local bus (MRQn/RW/BEn/READYn).
// PARAMETERS
// NSRC      16      number of maskable sources, 1..16; source i maps to level i; unused levels read 0
// NMI_LEN   4       CE cycles NMIn is held low per NMI event, >=2
// PORTS
// CLK      in   1      system clock
// RES      in   1      synchronous reset, active-high
// CE       in   1      clock enable; all state advances only on CLK edges with CE=1
// IRQ      in   NSRC   maskable request lines, active-high
// NMI_REQ  in   1      NMI request, active-high, rising-edge sensitive
// SEL      in   1      address decode for this block (from system decoder)
// A        in   2      word address, CPU A[3:2]
// MRQn     in   1      memory request, active-low
// RW       in   1      1=read, 0=write
// BEn      in   4      byte enables, active-low
// D_I      in   32     write data
// D_O      out  32     read data, valid while READYn=0
// READYn   out  1      bus ready, active-low
// INT      out  1      maskable interrupt request to CPU
// INTVn    out  4      active-low level of INT request (CPU INTVn)
// NMIn     out  1      non-maskable interrupt to CPU, active-low
// BEHAVIOUR
// - Reset (RES=1 at any CLK edge, CE ignored): all regs 0; INT=0, INTVn=4'hF, NMIn=1, READYn=1, D_O=0; bus txn aborted.
// - Registers (A): 0 PEND [NSRC-1:0] RO, write-1-clears edge sources; 1 ENABLE RW; 2 EDGE RW (1=edge, 0=level);
//   3 CTRL: bit0 INT global enable RW, bit8 NMI busy RO, bit16 SWNMI (macro only). Unimplemented bits read 0.
// - Byte writes honour BEn; a register byte written with BEn bit high is unchanged.
// - Sampling, per CE edge: irq_q<=IRQ. Level source: pend[i]<=IRQ[i]. Edge source: pend[i] set on IRQ[i]&~irq_q[i].
// - Same-edge set and W1C clear of pend[i]: set wins. Writing EDGE does not clear pend; level bits re-track next CE.
// - Output stage, registered on CE: act=pend&ENABLE, gated by CTRL.0. INT<=|act; INTVn<=~(highest set index of act).
//   No active source: INT=0, INTVn=4'hF. Latency IRQ edge -> INT/INTVn valid: 2 CE cycles.
// - INTVn never changes without INT remaining coherent: both come from the same registered stage.
// - No CPU acknowledge exists: edge sources stay pending until W1C; level sources follow IRQ.
// - NMI FSM: IDLE -> ASSERT on NMI_REQ rising edge (nmi_q register); ASSERT holds NMIn=0 for NMI_LEN CE cycles,
//   then IDLE with NMIn=1. Edges during ASSERT are dropped. NMI is unaffected by ENABLE/CTRL.0.
// - Bus FSM: IDLE -> ACK when CE & ~MRQn & SEL; ACK: READYn=0 one CE cycle, D_O=reg (read) / write commit
//   on that edge; then WAIT until MRQn=1 (prevents double ack), then IDLE. One wait state per access.
// - Read of PEND returns value at ACK entry; reads have no side effects.
// - RES mid-transfer: READYn returns to 1 immediately at the reset edge; no write committed.
// CONFIGURATION
// - V810_INTC_SWNMI_EN defined: write of 1 to CTRL bit16 triggers NMI FSM exactly as an NMI_REQ edge
//   (ignored if ASSERT); bit reads 0. Not defined: bit16 is read-0/write-ignored; NMI only from NMI_REQ.
// TESTING
// - Reset: RES=1 3 clk -> INT=0, INTVn=4'hF, NMIn=1, READYn=1; read all 4 regs -> 0.
// - ENABLE=0x0100, CTRL=1, IRQ[8] level 1 -> INT=1, INTVn=~4'd8=4'h7 after 2 CE; IRQ[8]=0 -> INT=0 after 2 CE.
// - IRQ[3], IRQ[12] both level-active, ENABLE=0xFFFF -> INTVn=4'h3 (level 12); ENABLE=0x0008 -> INTVn=4'hC.
// - EDGE[5]=1, pulse IRQ[5] one CE -> PEND=0x20, INT stays 1; W1C 0x20 same CE as new edge -> PEND stays 0x20.
// - NMI_REQ rise -> NMIn=0 exactly NMI_LEN CE cycles; 2nd rise during ASSERT ignored; NMIn low while ENABLE=0.
// - Hold MRQn=0 4 CE cycles on one read -> exactly one READYn=0 CE cycle; with V810_INTC_SWNMI_EN write
//   CTRL=0x10000 -> NMIn=0 for NMI_LEN, without macro -> NMIn stays 1.

Source files
------------

// File: rtl/v810_intc.sv
// V810 interrupt controller: latches/masks/prioritises NSRC level/edge sources plus one NMI,
// programmed over the V810 local bus. Optional SW NMI trigger via macro V810_INTC_SWNMI_EN.
module v810_intc #(
    parameter int unsigned NSRC    = 16,
    parameter int unsigned NMI_LEN = 4
) (
    input  logic            CLK,
    input  logic            RES,
    input  logic            CE,
    input  logic [NSRC-1:0] IRQ,
    input  logic            NMI_REQ,
    input  logic            SEL,
    input  logic [1:0]      A,
    input  logic            MRQn,
    input  logic            RW,
    input  logic [3:0]      BEn,
    input  logic [31:0]     D_I,
    output logic [31:0]     D_O,
    output logic            READYn,
    output logic            INT,
    output logic [3:0]      INTVn,
    output logic            NMIn
);
    localparam int unsigned CW = $clog2(NMI_LEN);

    typedef enum logic [1:0] {BusIdle, BusAck, BusWait} bus_state_e;
    typedef enum logic       {NmiIdle, NmiAssert} nmi_state_e;

    bus_state_e      bus_q, bus_d;
    nmi_state_e      nmi_st_q, nmi_st_d;
    logic [NSRC-1:0] pend_q, pend_d, enable_q, enable_d, edge_q, edge_d, irq_q, irq_d;
    logic            ctrl_en_q, ctrl_en_d, nmi_q, nmi_d, int_q, int_d;
    logic [3:0]      intvn_q, intvn_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [31:0]     rdata_q, rdata_d;

    logic [31:0]     wmask, rdata;
    logic [NSRC-1:0] wbits, mbits, clr, act;
    logic [3:0]      lvl;
    logic            commit, sw_trig;

    always_comb begin
        wmask  = {{8{~BEn[3]}}, {8{~BEn[2]}}, {8{~BEn[1]}}, {8{~BEn[0]}}};
        wbits  = D_I[NSRC-1:0];
        mbits  = wmask[NSRC-1:0];
        commit = (bus_q == BusAck) && !RW;

        rdata = '0;
        case (A)
            2'd0:    rdata[NSRC-1:0] = pend_q;
            2'd1:    rdata[NSRC-1:0] = enable_q;
            2'd2:    rdata[NSRC-1:0] = edge_q;
            default: begin
                rdata[0] = ctrl_en_q;
                rdata[8] = (nmi_st_q == NmiAssert);
            end
        endcase

`ifdef V810_INTC_SWNMI_EN
        sw_trig = commit && (A == 2'd3) && !BEn[2] && D_I[16];
`else
        sw_trig = 1'b0;
`endif

        clr = (commit && A == 2'd0) ? (wbits & mbits) : '0;
        act = pend_q & enable_q & {NSRC{ctrl_en_q}};
        lvl = 4'd0;
        for (int i = 0; i < NSRC; i++) begin
            if (act[i]) lvl = 4'(i);
        end

        bus_d     = bus_q;
        nmi_st_d  = nmi_st_q;
        pend_d    = pend_q;
        enable_d  = enable_q;
        edge_d    = edge_q;
        irq_d     = irq_q;
        ctrl_en_d = ctrl_en_q;
        nmi_d     = nmi_q;
        int_d     = int_q;
        intvn_d   = intvn_q;
        cnt_d     = cnt_q;
        rdata_d   = rdata_q;

        if (CE) begin
            irq_d   = IRQ;
            nmi_d   = NMI_REQ;
            // Level sources track IRQ; edge sources latch, and a new edge beats a W1C clear.
            pend_d  = (~edge_q & IRQ) | (edge_q & ((IRQ & ~irq_q) | (pend_q & ~clr)));
            int_d   = |act;
            intvn_d = (|act) ? ~lvl : 4'hF;

            if (commit && A == 2'd1) enable_d = (enable_q & ~mbits) | (wbits & mbits);
            if (commit && A == 2'd2) edge_d = (edge_q & ~mbits) | (wbits & mbits);
            if (commit && A == 2'd3 && !BEn[0]) ctrl_en_d = D_I[0];

            unique case (bus_q)
                BusIdle: begin
                    if (!MRQn && SEL) begin
                        bus_d   = BusAck;
                        rdata_d = rdata;
                    end
                end
                BusAck:  bus_d = BusWait;
                BusWait: if (MRQn) bus_d = BusIdle;
                default: bus_d = BusIdle;
            endcase

            unique case (nmi_st_q)
                NmiIdle: begin
                    if ((NMI_REQ && !nmi_q) || sw_trig) begin
                        nmi_st_d = NmiAssert;
                        cnt_d    = '0;
                    end
                end
                NmiAssert: begin
                    if (cnt_q == CW'(NMI_LEN - 1)) nmi_st_d = NmiIdle;
                    else cnt_d = cnt_q + 1'b1;
                end
                default: nmi_st_d = NmiIdle;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RES) begin
            bus_q     <= BusIdle;
            nmi_st_q  <= NmiIdle;
            pend_q    <= '0;
            enable_q  <= '0;
            edge_q    <= '0;
            irq_q     <= '0;
            ctrl_en_q <= 1'b0;
            nmi_q     <= 1'b0;
            int_q     <= 1'b0;
            intvn_q   <= 4'hF;
            cnt_q     <= '0;
            rdata_q   <= '0;
        end else begin
            bus_q     <= bus_d;
            nmi_st_q  <= nmi_st_d;
            pend_q    <= pend_d;
            enable_q  <= enable_d;
            edge_q    <= edge_d;
            irq_q     <= irq_d;
            ctrl_en_q <= ctrl_en_d;
            nmi_q     <= nmi_d;
            int_q     <= int_d;
            intvn_q   <= intvn_d;
            cnt_q     <= cnt_d;
            rdata_q   <= rdata_d;
        end
    end

    assign READYn = (bus_q != BusAck);
    assign D_O    = (bus_q == BusAck) ? rdata_q : 32'h0;
    assign INT    = int_q;
    assign INTVn  = intvn_q;
    assign NMIn   = (nmi_st_q != NmiAssert);

endmodule

// File: tb/tb_v810_intc.sv
// Directed self-checking bench for v810_intc (NSRC=16, NMI_LEN=4).
module tb_v810_intc;
    localparam int NMI_LEN = 4;
`ifdef V810_INTC_SWNMI_EN
    localparam int SWNMI_LOW = NMI_LEN;
`else
    localparam int SWNMI_LOW = 0;
`endif

    logic        CLK = 1'b0;
    logic        RES = 1'b1;
    logic        CE = 1'b1;
    logic [15:0] IRQ = '0;
    logic        NMI_REQ = 1'b0;
    logic        SEL = 1'b1;
    logic [1:0]  A = '0;
    logic        MRQn = 1'b1;
    logic        RW = 1'b1;
    logic [3:0]  BEn = 4'hF;
    logic [31:0] D_I = '0;
    logic [31:0] D_O;
    logic        READYn, INT, NMIn;
    logic [3:0]  INTVn;

    int n_assert = 0;
    int n_fail = 0;

    v810_intc #(.NSRC(16), .NMI_LEN(NMI_LEN)) dut (
        .CLK(CLK), .RES(RES), .CE(CE), .IRQ(IRQ), .NMI_REQ(NMI_REQ), .SEL(SEL), .A(A),
        .MRQn(MRQn), .RW(RW), .BEn(BEn), .D_I(D_I), .D_O(D_O), .READYn(READYn), .INT(INT),
        .INTVn(INTVn), .NMIn(NMIn)
    );

    always #5 CLK = ~CLK;

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic bus_xfer(input logic rw, input logic [1:0] addr, input logic [3:0] ben,
                            input logic [31:0] wd, output logic [31:0] rd);
        bit got = 0;
        A = addr; RW = rw; BEn = ben; D_I = wd; SEL = 1'b1; MRQn = 1'b0; rd = '0;
        for (int k = 0; k < 8 && !got; k++) begin
            tick(1);
            if (READYn === 1'b0) begin
                got = 1;
                rd = D_O;
            end
        end
        MRQn = 1'b1;
        n_assert++;
        if (!got) begin
            n_fail++;
            $display("FAIL bus_ack: READYn never went 0 (addr %0d)", addr);
        end
        tick(2);
    endtask

    task automatic wr(input logic [1:0] addr, input logic [31:0] wd);
        logic [31:0] dummy;
        bus_xfer(1'b0, addr, 4'h0, wd, dummy);
    endtask

    task automatic rd(input logic [1:0] addr, output logic [31:0] d);
        bus_xfer(1'b1, addr, 4'h0, 32'h0, d);
    endtask

    task automatic test_reset;
        logic [31:0] d;
        RES = 1'b1;
        tick(3);
        n_assert++; if (INT !== 1'b0) begin n_fail++; $display("FAIL reset_int: got %b want 0", INT); end
        n_assert++; if (INTVn !== 4'hF) begin n_fail++; $display("FAIL reset_intvn: got %h want f", INTVn); end
        n_assert++; if (NMIn !== 1'b1) begin n_fail++; $display("FAIL reset_nmin: got %b want 1", NMIn); end
        n_assert++; if (READYn !== 1'b1) begin n_fail++; $display("FAIL reset_readyn: got %b want 1", READYn); end
        n_assert++; if (D_O !== 32'h0) begin n_fail++; $display("FAIL reset_do: got %h want 0", D_O); end
        RES = 1'b0;
        for (int a = 0; a < 4; a++) begin
            rd(2'(a), d);
            n_assert++;
            if (d !== 32'h0) begin n_fail++; $display("FAIL reset_reg%0d: got %h want 0", a, d); end
        end
    endtask

    task automatic test_level;
        wr(2'd1, 32'h0100);
        wr(2'd3, 32'h1);
        CE = 1'b0;
        IRQ[8] = 1'b1;
        tick(4);
        n_assert++; if (INT !== 1'b0) begin n_fail++; $display("FAIL ce_gate: INT got %b want 0", INT); end
        CE = 1'b1;
        tick(1);
        n_assert++; if (INT !== 1'b0) begin n_fail++; $display("FAIL level_lat1: INT got %b want 0", INT); end
        tick(1);
        n_assert++; if (INT !== 1'b1) begin n_fail++; $display("FAIL level_int: got %b want 1", INT); end
        n_assert++; if (INTVn !== 4'h7) begin n_fail++; $display("FAIL level_intvn: got %h want 7", INTVn); end
        IRQ[8] = 1'b0;
        tick(2);
        n_assert++; if (INT !== 1'b0) begin n_fail++; $display("FAIL level_off: INT got %b want 0", INT); end
        n_assert++; if (INTVn !== 4'hF) begin n_fail++; $display("FAIL level_off_intvn: got %h want f", INTVn); end
    endtask

    task automatic test_priority;
        logic [31:0] d, dummy;
        IRQ = 16'h1008;
        wr(2'd1, 32'hFFFF);
        tick(1);
        n_assert++; if (INTVn !== 4'h3) begin n_fail++; $display("FAIL prio_12: INTVn got %h want 3", INTVn); end
        wr(2'd1, 32'h0008);
        tick(1);
        n_assert++; if (INTVn !== 4'hC) begin n_fail++; $display("FAIL prio_3: INTVn got %h want c", INTVn); end
        bus_xfer(1'b0, 2'd1, 4'b1110, 32'h0000FFFF, dummy);
        rd(2'd1, d);
        n_assert++; if (d !== 32'h00FF) begin n_fail++; $display("FAIL byte_en: ENABLE got %h want ff", d); end
        rd(2'd0, d);
        n_assert++; if (d !== 32'h1008) begin n_fail++; $display("FAIL pend_level: got %h want 1008", d); end
        wr(2'd3, 32'h0);
        tick(1);
        n_assert++; if (INT !== 1'b0) begin n_fail++; $display("FAIL global_gate: INT got %b want 0", INT); end
        wr(2'd3, 32'h1);
        IRQ = '0;
        wr(2'd1, 32'h0);
    endtask

    task automatic test_edge;
        logic [31:0] d;
        wr(2'd2, 32'h20);
        wr(2'd1, 32'h20);
        IRQ[5] = 1'b1;
        tick(1);
        IRQ[5] = 1'b0;
        tick(2);
        n_assert++; if (INT !== 1'b1) begin n_fail++; $display("FAIL edge_int: got %b want 1", INT); end
        n_assert++; if (INTVn !== 4'hA) begin n_fail++; $display("FAIL edge_intvn: got %h want a", INTVn); end
        rd(2'd0, d);
        n_assert++; if (d !== 32'h20) begin n_fail++; $display("FAIL edge_pend: got %h want 20", d); end
        // W1C commit edge coincides with a fresh IRQ[5] rising edge
        A = 2'd0; RW = 1'b0; BEn = 4'h0; D_I = 32'h20; MRQn = 1'b0;
        tick(1);
        n_assert++; if (READYn !== 1'b0) begin n_fail++; $display("FAIL w1c_ack: READYn got %b want 0", READYn); end
        IRQ[5] = 1'b1;
        MRQn = 1'b1;
        tick(1);
        IRQ[5] = 1'b0;
        tick(1);
        rd(2'd0, d);
        n_assert++; if (d !== 32'h20) begin n_fail++; $display("FAIL set_wins: PEND got %h want 20", d); end
        wr(2'd0, 32'h20);
        tick(2);
        rd(2'd0, d);
        n_assert++; if (d !== 32'h0) begin n_fail++; $display("FAIL w1c: PEND got %h want 0", d); end
        n_assert++; if (INT !== 1'b0) begin n_fail++; $display("FAIL w1c_int: got %b want 0", INT); end
        wr(2'd2, 32'h0);
        wr(2'd1, 32'h0);
    endtask

    task automatic test_nmi;
        int low = 0;
        wr(2'd3, 32'h0);
        NMI_REQ = 1'b1;
        tick(1);
        n_assert++; if (NMIn !== 1'b0) begin n_fail++; $display("FAIL nmi_assert: NMIn got %b want 0", NMIn); end
        low++;
        NMI_REQ = 1'b0;
        tick(1);
        if (NMIn === 1'b0) low++;
        NMI_REQ = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick(1);
            if (NMIn === 1'b0) low++;
        end
        NMI_REQ = 1'b0;
        n_assert++; if (low != NMI_LEN) begin n_fail++; $display("FAIL nmi_len: low %0d want %0d", low, NMI_LEN); end
    endtask

    task automatic test_bus_hold;
        int acks = 0;
        A = 2'd3; RW = 1'b1; BEn = 4'h0; MRQn = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick(1);
            if (READYn === 1'b0) acks++;
        end
        MRQn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick(1);
            if (READYn === 1'b0) acks++;
        end
        n_assert++; if (acks != 1) begin n_fail++; $display("FAIL single_ack: got %0d want 1", acks); end
    endtask

    task automatic test_reset_mid;
        logic [31:0] d;
        A = 2'd1; RW = 1'b0; BEn = 4'h0; D_I = 32'hFFFF; MRQn = 1'b0;
        tick(1);
        n_assert++; if (READYn !== 1'b0) begin n_fail++; $display("FAIL mid_ack: READYn got %b want 0", READYn); end
        RES = 1'b1;
        tick(1);
        n_assert++; if (READYn !== 1'b1) begin n_fail++; $display("FAIL mid_reset: READYn got %b want 1", READYn); end
        RES = 1'b0;
        MRQn = 1'b1;
        tick(1);
        rd(2'd1, d);
        n_assert++; if (d !== 32'h0) begin n_fail++; $display("FAIL mid_nocommit: ENABLE got %h want 0", d); end
    endtask

    task automatic test_swnmi;
        int low = 0;
        logic [31:0] d;
        A = 2'd3; RW = 1'b0; BEn = 4'h0; D_I = 32'h0001_0000; MRQn = 1'b0;
        tick(1);
        MRQn = 1'b1;
        for (int k = 0; k < 10; k++) begin
            tick(1);
            if (NMIn === 1'b0) low++;
        end
        n_assert++;
        if (low != SWNMI_LOW) begin n_fail++; $display("FAIL swnmi: low %0d want %0d", low, SWNMI_LOW); end
        rd(2'd3, d);
        n_assert++; if (d !== 32'h0) begin n_fail++; $display("FAIL swnmi_rd: CTRL got %h want 0", d); end
    endtask

    initial begin
        test_reset();
        test_level();
        test_priority();
        test_edge();
        test_nmi();
        test_bus_hold();
        test_reset_mid();
        test_swnmi();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

endmodule
